// File: rtl/demux_l2_pkg.sv
// Shared definitions for the layer-2 1:2 byte demux scheduler:
// state encoding, default idle symbol and the sync counter width helper.
package demux_l2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_IDLE_SYM = 8'hBC;

  // Bits needed to hold the values 0..n.
  function automatic int sync_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single-lane byte FIFO: synchronous storage, async-reset pointers, and a
// push that is accepted while full as long as a pop happens on the same edge.
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/demux_l2_scheduler.sv
// Layer-2 1:2 demux sequencer: aligns on the idle symbol, alternates accepted
// bytes between two lane FIFOs, drains each lane under pause, flags overflow.
module demux_l2_scheduler
  import demux_l2_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(DEFAULT_IDLE_SYM),
  parameter int                SYNC_COUNT = 4
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              enable,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pause0,
  input  logic              pause1,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0,
  output logic [DATA_W-1:0] dataout1,
  output logic              active,
  output logic              lane_sel,
  output logic              overflow0,
  output logic              overflow1
);

  localparam int CNT_W = sync_cnt_w(SYNC_COUNT);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   sync_cnt;
  logic [CNT_W-1:0]   sync_cnt_nxt;
  logic               accept;
  logic               run_entry;
  logic               idle_seen;

  logic               push0, push1, pop0, pop1;
  logic               full0, full1, empty0, empty1;
  logic [DATA_W-1:0]  fifo_dout0, fifo_dout1;

  assign idle_seen = !valid_in && (data_in == IDLE_SYM);
  assign active    = (state == ST_RUN);

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sync_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    accept       = 1'b0;
    run_entry    = 1'b0;
    case (state)
      ST_IDLE: begin
        sync_cnt_nxt = '0;
        if (enable) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable) begin
          state_nxt    = ST_IDLE;
          sync_cnt_nxt = '0;
        end else if (idle_seen) begin
          // Entering RUN on the edge that would make the count reach SYNC_COUNT.
          if (sync_cnt == CNT_W'(SYNC_COUNT - 1)) begin
            state_nxt    = ST_RUN;
            sync_cnt_nxt = '0;
            run_entry    = 1'b1;
          end else begin
            sync_cnt_nxt = sync_cnt + 1'b1;
          end
        end else begin
          sync_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        accept = valid_in;
        if (!enable) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty0 && empty1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign push0 = accept && !lane_sel;
  assign push1 = accept &&  lane_sel;
  assign pop0  = !empty0 && !pause0;
  assign pop1  = !empty1 && !pause1;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk_4f), .reset(reset), .push(push0), .pop(pop0),
    .din(data_in), .dout(fifo_dout0), .full(full0), .empty(empty0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk_4f), .reset(reset), .push(push1), .pop(pop1),
    .din(data_in), .dout(fifo_dout1), .full(full1), .empty(empty1)
  );

  // lane_sel toggles on drops too, so even/odd pairing survives an overflow.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      lane_sel  <= 1'b0;
      overflow0 <= 1'b0;
      overflow1 <= 1'b0;
      validout0 <= 1'b0;
      validout1 <= 1'b0;
      dataout0  <= '0;
      dataout1  <= '0;
    end else begin
      if (run_entry)   lane_sel <= 1'b0;
      else if (accept) lane_sel <= ~lane_sel;
      if (push0 && full0 && !pop0) overflow0 <= 1'b1;
      if (push1 && full1 && !pop1) overflow1 <= 1'b1;
      validout0 <= pop0;
      validout1 <= pop1;
      if (pop0) dataout0 <= fifo_dout0;
      if (pop1) dataout1 <= fifo_dout1;
    end
  end

endmodule

// File: tb/tb_demux_l2_scheduler.sv
// Directed bench for demux_l2_scheduler: sync entry, alternation, full lane
// handling, drain-on-disable and asynchronous reset, against hand-computed values.
module tb_demux_l2_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic       valid_in;
  logic [7:0] data_in;
  logic       pause0;
  logic       pause1;
  logic       validout0;
  logic       validout1;
  logic [7:0] dataout0;
  logic [7:0] dataout1;
  logic       active;
  logic       lane_sel;
  logic       overflow0;
  logic       overflow1;

  int vec_count  = 0;
  int miscompares = 0;

  logic [7:0] got0[$];
  logic [7:0] got1[$];

  demux_l2_scheduler dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable), .valid_in(valid_in),
    .data_in(data_in), .pause0(pause0), .pause1(pause1),
    .validout0(validout0), .validout1(validout1),
    .dataout0(dataout0), .dataout1(dataout1), .active(active),
    .lane_sel(lane_sel), .overflow0(overflow0), .overflow1(overflow1)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stream input, sample 1 time unit after the edge, log lane outputs.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
    if (validout0) got0.push_back(dataout0);
    if (validout1) got1.push_back(dataout1);
  endtask

  task automatic compareLane(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    checkOutput({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i])
      if (i < got.size()) checkOutput($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  logic [7:0] exp_v0[6] = '{0, 1, 0, 1, 0, 0};
  logic [7:0] exp_d0[6] = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h03};
  logic [7:0] exp_v1[6] = '{0, 0, 1, 0, 1, 0};
  logic [7:0] exp_d1[6] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h04, 8'h04};
  logic [7:0] alt_in[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hBC, 8'hBC};

  initial begin
    reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 8'hBC;
    pause0 = 1'b0; pause1 = 1'b0;
    #12;
    checkOutput("rst_active",   active,    1'b0);
    checkOutput("rst_lane_sel", lane_sel,  1'b0);
    checkOutput("rst_vout0",    validout0, 1'b0);
    checkOutput("rst_vout1",    validout1, 1'b0);
    checkOutput("rst_dout0",    dataout0,  8'h00);
    checkOutput("rst_ovf0",     overflow0, 1'b0);
    reset = 1'b0;

    // Sync with a non-idle byte injected at the third idle cycle.
    enable = 1'b1;
    applyStimulus(1'b0, 8'hBC);
    checkOutput("sync_enter", active, 1'b0);
    applyStimulus(1'b0, 8'hBC);
    applyStimulus(1'b0, 8'hBC);
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'hBC);
      checkOutput($sformatf("sync_restart_%0d", i), active, 1'b0);
    end
    applyStimulus(1'b0, 8'hBC);
    checkOutput("sync_run",      active,   1'b1);
    checkOutput("sync_lane_sel", lane_sel, 1'b0);

    // Alternation with cycle-exact output checks.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, alt_in[i]);
      checkOutput($sformatf("alt_v0_%0d", i), validout0, exp_v0[i][0]);
      checkOutput($sformatf("alt_d0_%0d", i), dataout0,  exp_d0[i]);
      checkOutput($sformatf("alt_v1_%0d", i), validout1, exp_v1[i][0]);
      checkOutput($sformatf("alt_d1_%0d", i), dataout1,  exp_d1[i]);
    end
    checkOutput("alt_lane_sel", lane_sel, 1'b0);

    // Lane 0 full, pause released on the same edge as the next lane-0 push.
    got0.delete(); got1.delete();
    pause0 = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h30 + 8'(i));
    pause0 = 1'b0;
    applyStimulus(1'b1, 8'h38);
    applyStimulus(1'b1, 8'h39);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'hBC);
    checkOutput("fullpop_ovf0", overflow0, 1'b0);
    compareLane("fullpop_l0", got0, '{8'h30, 8'h32, 8'h34, 8'h36, 8'h38});
    compareLane("fullpop_l1", got1, '{8'h31, 8'h33, 8'h35, 8'h37, 8'h39});

    // Overflow: fifth lane-0 byte (index 8) is dropped.
    got0.delete(); got1.delete();
    pause0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h20 + 8'(i));
      if (i == 6) checkOutput("ovf_before", overflow0, 1'b0);
      if (i == 8) checkOutput("ovf_set",    overflow0, 1'b1);
    end
    applyStimulus(1'b0, 8'hBC);
    pause0 = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hBC);
    checkOutput("ovf_ovf1",     overflow1, 1'b0);
    checkOutput("ovf_lane_sel", lane_sel,  1'b0);
    compareLane("ovf_l0", got0, '{8'h20, 8'h22, 8'h24, 8'h26});
    compareLane("ovf_l1", got1, '{8'h21, 8'h23, 8'h25, 8'h27, 8'h29});

    // Drain: byte on the disabling edge still accepted, later bytes ignored.
    got0.delete(); got1.delete();
    pause0 = 1'b1; pause1 = 1'b1;
    applyStimulus(1'b1, 8'h40);
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b1, 8'h42);
    enable = 1'b0;
    applyStimulus(1'b1, 8'h43);
    checkOutput("drain_active", active, 1'b0);
    pause0 = 1'b0;
    applyStimulus(1'b1, 8'h44);
    applyStimulus(1'b1, 8'h45);
    applyStimulus(1'b0, 8'hBC);
    enable = 1'b1;
    applyStimulus(1'b0, 8'hBC);
    applyStimulus(1'b0, 8'hBC);
    pause1 = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'hBC);
    checkOutput("drain_resync_wait", active, 1'b0);
    applyStimulus(1'b0, 8'hBC);
    checkOutput("drain_resync_run", active, 1'b1);
    checkOutput("drain_ovf_sticky", overflow0, 1'b1);
    compareLane("drain_l0", got0, '{8'h40, 8'h42});
    compareLane("drain_l1", got1, '{8'h41, 8'h43});

    // Asynchronous reset mid-RUN with bytes buffered.
    pause0 = 1'b1; pause1 = 1'b1;
    applyStimulus(1'b1, 8'h50);
    applyStimulus(1'b1, 8'h51);
    valid_in = 1'b0; data_in = 8'hBC;
    #3 reset = 1'b1;
    #1;
    checkOutput("arst_active", active,    1'b0);
    checkOutput("arst_dout0",  dataout0,  8'h00);
    checkOutput("arst_dout1",  dataout1,  8'h00);
    checkOutput("arst_ovf0",   overflow0, 1'b0);
    @(posedge clk_4f);
    #3 reset = 1'b0;
    pause0 = 1'b0; pause1 = 1'b0;
    got0.delete(); got1.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'hBC);
      checkOutput($sformatf("resync_wait_%0d", i), active, 1'b0);
    end
    applyStimulus(1'b0, 8'hBC);
    checkOutput("resync_run", active, 1'b1);
    applyStimulus(1'b0, 8'hBC);
    applyStimulus(1'b0, 8'hBC);
    checkOutput("resync_no_stale0", got0.size(), 0);
    checkOutput("resync_no_stale1", got1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
